// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage.
// Holds the fetch FSM encoding, the bubble word and the reset PC.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    pc4:   32'h0,
    instr: NOP_INSTR,
    valid: 1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats enable, async active-low reset.
// Flush and reset both load the bubble word.
module if_id_reg
  import pipe_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   i_en,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_flush) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, redirect, stall.
// IF_STAGE_PERF_CNT_EN adds fetch_count / stall_count outputs.
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_IDWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_buf;
  logic         r_kill;
  logic         w_kill_nxt;
  logic         w_go;
  logic         w_rsp;
  logic         w_deliver;
  logic [31:0]  w_pc4;
  logic [31:0]  w_instr;
  logic [31:0]  w_tgt;
  if_id_t       w_ifid_d;
  if_id_t       w_ifid_q;

  assign w_go  = PCWrite & IF_IDWrite;
  assign w_pc4 = r_pc + 32'd4;
  assign w_tgt = branch_target & ~32'h3;
  assign w_rsp = (r_state == S_WAIT) & imem_rvalid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_buf   <= NOP_INSTR;
    end else begin
      r_state <= w_next;
      r_kill  <= w_kill_nxt;
      if (branch_taken) begin
        r_pc  <= w_tgt;
        r_buf <= NOP_INSTR;
      end else begin
        if (w_deliver) r_pc <= w_pc4;
        if (w_rsp && !r_kill && !w_go)
          r_buf <= imem_rdata;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_kill_nxt = r_kill;
    unique case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ: begin
        w_next = S_WAIT;
        if (branch_taken) w_kill_nxt = 1'b1;
      end
      S_WAIT: begin
        if (branch_taken) begin
          // A response landing with the redirect is simply dropped.
          w_next     = imem_rvalid ? S_REQ : S_WAIT;
          w_kill_nxt = !imem_rvalid;
        end else if (imem_rvalid) begin
          w_next     = (r_kill || w_go) ? S_REQ : S_HOLD;
          w_kill_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken || w_go) w_next = S_REQ;
      end
    endcase
  end

  always_comb begin
    imem_req  = (r_state == S_REQ);
    imem_addr = r_pc;
    w_deliver = !branch_taken && w_go &&
                ((w_rsp && !r_kill) ||
                 (r_state == S_HOLD));
    w_instr   = (r_state == S_HOLD) ? r_buf
                                    : imem_rdata;
    w_ifid_d  = IF_ID_BUBBLE;
    if (w_deliver) begin
      w_ifid_d.pc4   = w_pc4;
      w_ifid_d.instr = w_instr;
      w_ifid_d.valid = 1'b1;
    end
  end

  if_id_reg u_if_id (
    .clock   (clock),
    .reset   (reset),
    .i_en    (IF_IDWrite),
    .i_flush (branch_taken),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign IF_ID_PC4   = w_ifid_q.pc4;
  assign IF_ID_Instr = w_ifid_q.instr;
  assign IF_ID_Valid = w_ifid_q.valid;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      if (w_deliver) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (!IF_IDWrite) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded at reset (word aligned).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 PCWrite  input  1  PC advance enable from the hazard unit.
REQ-005 IF_IDWrite  input  1  IF/ID load enable from the hazard unit.
REQ-006 branch_taken  input  1  redirect request, resolved downstream.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_req  output  1  one-cycle fetch request pulse.
REQ-009 imem_addr  output  32  fetch address; SHALL equal the PC while imem_req=1.
REQ-010 imem_rvalid  input  1  instruction return strobe, at least 1 cycle after the request.
REQ-011 imem_rdata  input  32  returned instruction.
REQ-012 IF_ID_PC4, IF_ID_Instr  output  32 each  registered PC+4 and instruction.
REQ-013 IF_ID_Valid  output  1  1 = real instruction, 0 = bubble.

Function
REQ-014 The FSM SHALL have four states: IDLE, REQ, WAIT, HOLD; one request is outstanding at most.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-016 REQ: imem_req=1 and imem_addr=PC for one cycle, then WAIT.
REQ-017 WAIT, rvalid with PCWrite=1 and IF_IDWrite=1: IF/ID <= {PC+4, rdata, 1}; PC <= PC+4; next state REQ.
REQ-018 WAIT, rvalid with either enable low: rdata captured in a one-entry buffer; PC held; next state HOLD.
REQ-019 HOLD: when both enables are 1, IF/ID <= {PC+4, buffer, 1}; PC <= PC+4; next state REQ.
REQ-020 In any cycle with no instruction delivered and IF_IDWrite=1, IF/ID SHALL load a bubble (Instr=32'h0, Valid=0, PC4=0); with IF_IDWrite=0, IF/ID SHALL hold.
REQ-021 branch_taken SHALL have the highest priority: PC <= {branch_target[31:2],2'b00}, IF/ID <= bubble (even if IF_IDWrite=0), buffer discarded.
REQ-022 Redirect in WAIT, or in REQ (request already issued), SHALL set a kill flag and next state WAIT; redirect in IDLE or HOLD SHALL go to REQ.
REQ-023 An rvalid seen with kill=1 SHALL be dropped, clear kill and go to REQ; no IF/ID load and no PC change.
REQ-024 Redirect coincident with rvalid in WAIT SHALL drop that response; kill stays 0; next state REQ.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-027 While reset=0: PC=RESET_PC, state=IDLE, kill=0, buffer=0, imem_req=0, imem_addr=RESET_PC, IF_ID_PC4=0, IF_ID_Instr=0, IF_ID_Valid=0.
REQ-028 Reset asserted mid-request SHALL abandon it; a later rvalid SHALL be ignored until the next REQ.

Configuration
REQ-029 Macro IF_STAGE_PERF_CNT_EN, when defined, SHALL add outputs fetch_count[31:0] (+1 per Valid=1 IF/ID load) and stall_count[31:0] (+1 per cycle with IF_IDWrite=0). Both SHALL be cleared by reset and wrap.
REQ-030 When IF_STAGE_PERF_CNT_EN is undefined, those ports and counters SHALL NOT exist; other behaviour is identical.

Structure
REQ-031 Shared package pipe_pkg SHALL hold the fetch-state enum, the NOP/bubble constant 32'h0 and the default RESET_PC.
REQ-032 The IF/ID register SHALL be a sub-module if_id_reg with enable, flush and async active-low reset.

Verification
REQ-033 Reset release, rvalid 2 cycles after each request, enables=1 -> imem_addr 0,4,8; IF_ID_PC4 4,8,12 with Valid=1.
REQ-034 IF_IDWrite=PCWrite=0 for 3 cycles as rvalid returns 32'h8C220004 -> HOLD entered; IF/ID unchanged; on release the instruction is delivered once; no re-request of that PC.
REQ-035 branch_taken with target 32'h0000_0103 during WAIT -> pending response dropped; next imem_addr=32'h100; one bubble in IF/ID.
REQ-036 Redirect in the same cycle as rvalid -> Valid=0 next cycle; next fetch at target.
REQ-037 PC=32'hFFFF_FFFC fetch -> IF_ID_PC4=0; next imem_addr=0.
REQ-038 With IF_STAGE_PERF_CNT_EN: 5 deliveries and 3 stall cycles -> fetch_count=5, stall_count=3; reset mid-run clears both.
